// File: rtl/line_seq_pkg.sv
// Shared types and constants for the line sequencer slice.
package line_seq_pkg;

    localparam int LINE_W_DEF = 25;
    localparam int ADDR_W_DEF = 6;

    // Written to the result buffer when a line times out instead of completing.
    localparam logic [LINE_W_DEF-1:0] LINE_EOF = {LINE_W_DEF{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_ISSUE,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } line_seq_state_t;

endpackage

// File: rtl/line_sequencer_watchdog.sv
// RUN-cycle watchdog: loaded on clr, counts enabled cycles down and flags the
// TIMEOUT_CYCLES-th enabled cycle through a terminal-count compare.
module line_watchdog
    import line_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(TIMEOUT_CYCLES - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/line_sequencer.sv
// Steps NUM_LINES lines from line memory through the datapath controller with
// a start/done handshake. Optional RUN watchdog: define LINE_SEQ_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   FETCH | line-memory read of idx
//   LOAD  | read data lands in line, idx in count
//   ISSUE | dp_start pulse
//   RUN   | waiting for dp_done (or watchdog expiry)
//   WRITE | result written to idx, advance or finish
//   DONE  | run complete, start re-arms from idx 0
module line_sequencer
    import line_seq_pkg::*;
#(
    parameter int LINE_W         = LINE_W_DEF,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int NUM_LINES      = 64,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_rd_data,
    output logic [LINE_W-1:0] line,
    output logic [ADDR_W-1:0] count,
    output logic              dp_start,
    input  logic              dp_done,
    input  logic [LINE_W-1:0] dp_result,
    output logic              dp_abort,
    output logic              res_wr_en,
    output logic [LINE_W-1:0] res_wr_data,
    output logic              busy,
    output logic              all_done,
    output logic              err
);

    line_seq_state_t state, next_state;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] line_q;
    logic [ADDR_W-1:0] count_q;
    logic [LINE_W-1:0] res_q;
    logic              err_q;
    logic              last;
    logic              timeout;

    assign last = (idx == ADDR_W'(NUM_LINES - 1));

`ifdef LINE_SEQ_TIMEOUT_EN
    logic wd_expire;

    line_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_ISSUE),
        .en    (state == ST_RUN),
        .expire(wd_expire)
    );

    // A completion landing on the expiry cycle still counts as a completion.
    assign timeout = wd_expire && !dp_done;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) next_state = ST_FETCH;
            ST_FETCH:         next_state = ST_LOAD;
            ST_LOAD:          next_state = ST_ISSUE;
            ST_ISSUE:         next_state = ST_RUN;
            ST_RUN:           if (dp_done || timeout) next_state = ST_WRITE;
            ST_WRITE:         next_state = last ? ST_DONE : ST_FETCH;
            default:          next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx        <= '0;
            mem_addr_q <= '0;
            line_q     <= '0;
            count_q    <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx   <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_FETCH: mem_addr_q <= idx;
                ST_LOAD: begin
                    line_q  <= mem_rd_data;
                    count_q <= idx;
                end
                ST_RUN: begin
                    if (dp_done) begin
                        res_q <= dp_result;
                    end else if (timeout) begin
                        res_q <= LINE_W'(LINE_EOF);
                        err_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    mem_addr_q <= idx;
                    if (!last) idx <= idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Address follows idx during strobes and otherwise holds the last strobed value.
    always_comb begin
        mem_rd_en   = 1'b0;
        dp_start    = 1'b0;
        dp_abort    = 1'b0;
        res_wr_en   = 1'b0;
        busy        = 1'b1;
        all_done    = 1'b0;
        mem_addr    = mem_addr_q;
        res_wr_data = '0;
        case (state)
            ST_IDLE:  busy = 1'b0;
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx;
            end
            ST_ISSUE: dp_start = 1'b1;
            ST_RUN:   dp_abort = timeout;
            ST_WRITE: begin
                res_wr_en   = 1'b1;
                mem_addr    = idx;
                res_wr_data = res_q;
            end
            ST_DONE: begin
                busy     = 1'b0;
                all_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign line  = line_q;
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Scoreboard bench for line_sequencer: memory and datapath stubs, directed runs.
module tb_line_sequencer;
    import line_seq_pkg::*;

    localparam int LW = 25;
    localparam int AW = 6;
    localparam int NL = 4;
    localparam int TO = 8;
    localparam logic [LW-1:0] MASK = 25'h1FFFFFF;
    localparam logic [LW-1:0] JUNK = 25'h0A5A5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_rd_data = '0;
    logic [LW-1:0] line;
    logic [AW-1:0] count;
    logic          dp_start;
    logic          dp_done = 1'b0;
    logic [LW-1:0] dp_result = '0;
    logic          dp_abort;
    logic          res_wr_en;
    logic [LW-1:0] res_wr_data;
    logic          busy;
    logic          all_done;
    logic          err;

    line_sequencer #(
        .LINE_W(LW), .ADDR_W(AW), .NUM_LINES(NL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .line(line), .count(count),
        .dp_start(dp_start), .dp_done(dp_done), .dp_result(dp_result), .dp_abort(dp_abort),
        .res_wr_en(res_wr_en), .res_wr_data(res_wr_data),
        .busy(busy), .all_done(all_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  abort_cnt = 0;

    int            dly = 2;
    int            skip = -1;
    bit            spur = 1'b0;
    int            dp_tmr = 0;
    logic [LW-1:0] dp_val = '0;
    bit            rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    function automatic logic [LW-1:0] mem_word(input logic [AW-1:0] a);
        return LW'(a) + LW'(1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return mem_rd_en;
            1:       return all_done;
            default: return dp_start && (count == AW'(2));
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string name);
        int k;
        k = 0;
        while (!sig(which) && k < limit) begin
            step();
            k++;
        end
        check(name, 64'(sig(which)), 64'd1);
    endtask

    task automatic push_run(input int sk);
        wr_t e;
        for (int i = 0; i < NL; i++) begin
            e.addr = AW'(i);
            e.data = (i == sk) ? MASK : (mem_word(AW'(i)) ^ MASK);
            sb_q.push_back(e);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_line"}, 64'(line), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_res_wr_data"}, 64'(res_wr_data), 64'd0);
        check({tag, "_flags"},
              64'({mem_rd_en, dp_start, dp_abort, res_wr_en, busy, all_done, err}), 64'd0);
    endtask

    task automatic do_run(input int d, input int sk, input int exp_lat, input bit sp);
        int t0;
        dly  = d;
        skip = sk;
        spur = sp;
        push_run(sk);
        step();
        start = 1'b1;
        wait_for(0, 10, "fetch_begin");
        t0 = cyc;
        check("first_addr", 64'(mem_addr), 64'd0);
        start = 1'b0;
        wait_for(1, 400, "run_done");
        check("run_latency", 64'(cyc - t0), 64'(exp_lat));
        step();
        step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("all_done_hold", 64'(all_done), 64'd1);
    endtask

    // Line memory (1-cycle read latency) and datapath stub.
    initial begin
        forever begin
            @(negedge clk);
            mem_rd_data = rd_pend ? mem_word(rd_addr) : JUNK;
            rd_pend     = mem_rd_en;
            rd_addr     = mem_addr;
            dp_done     = 1'b0;
            dp_result   = JUNK;
            if (dp_tmr > 0) begin
                dp_tmr--;
                if (dp_tmr == 0) begin
                    dp_done   = 1'b1;
                    dp_result = dp_val;
                end
            end
            if (dp_start) begin
                dp_val = line ^ MASK;
                dp_tmr = (skip >= 0 && int'(count) == skip) ? 0 : dly;
            end
            if (spur && (dp_start || mem_rd_en)) begin
                dp_done   = 1'b1;
                dp_result = ~JUNK;
            end
        end
    end

    initial begin
        wr_t e;
        forever begin
            step();
            if (dp_abort) abort_cnt++;
            if (res_wr_en) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write", 64'(mem_addr), 64'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(res_wr_data), 64'(e.data));
                    check("wr_count", 64'(count), 64'(e.addr));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        step();
        step();
        step();
        check_zero("reset");
        rst = 1'b1;
        step();
        check_zero("idle");

        do_run(2, -1, 24, 1'b0);
        do_run(1, -1, 20, 1'b0);
        do_run(2, -1, 24, 1'b1);

`ifdef LINE_SEQ_TIMEOUT_EN
        abort_cnt = 0;
        do_run(2, 2, 30, 1'b0);
        check("abort_pulses", 64'(abort_cnt), 64'd1);
        check("err_set", 64'(err), 64'd1);
        do_run(1, -1, 20, 1'b0);
        check("err_cleared", 64'(err), 64'd0);
`endif

        // start held through DONE chains a second run from idx 0
        dly  = 1;
        skip = -1;
        spur = 1'b0;
        push_run(-1);
        push_run(-1);
        step();
        start = 1'b1;
        wait_for(0, 10, "held_fetch");
        wait_for(1, 200, "held_done1");
        step();
        check("held_refetch", 64'({mem_rd_en, all_done, mem_addr}), 64'h80);
        start = 1'b0;
        wait_for(1, 200, "held_done2");
        step();
        check("held_drained", 64'(sb_q.size()), 64'd0);

        // reset while line 2 is in RUN
        dly = 6;
        for (int i = 0; i < 2; i++) begin
            e_push(i);
        end
        step();
        start = 1'b1;
        wait_for(2, 100, "reach_line2");
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_zero("midrun_reset");
        rst    = 1'b1;
        dp_tmr = 0;
        step();
        check("midrun_drained", 64'(sb_q.size()), 64'd0);
        check("midrun_idle", 64'({busy, all_done}), 64'd0);
        do_run(1, -1, 20, 1'b0);

`ifndef LINE_SEQ_TIMEOUT_EN
        check("no_abort", 64'(abort_cnt), 64'd0);
        check("no_err", 64'(err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic e_push(input int i);
        wr_t e;
        e.addr = AW'(i);
        e.data = mem_word(AW'(i)) ^ MASK;
        sb_q.push_back(e);
    endtask

endmodule
